adc_capture_bram: RTL and testbench



---
 rtl/adc_capture_bram_if.sv | 50 +++++
 rtl/adc_capture_bram.sv | 165 ++++++++++++++++
 tb/tb_adc_capture_bram.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_capture_bram_if.sv
// -----------------------------------------------------------------------------
// adc_capture_bram_if
//   Bundles the ADC AXI4-Stream input and the native BRAM write port of the
//   capture engine.
//
//   Signals:
//     s_axis_tdata   ADC sample word (DATA_WIDTH)
//     s_axis_tvalid  sample valid
//     s_axis_tready  sample accept
//     bram_en        BRAM port enable
//     bram_we        byte write enables (DATA_WIDTH/8)
//     bram_addr      BRAM word address (ADDR_WIDTH)
//     bram_din       BRAM write data (DATA_WIDTH)
//
//   Modports:
//     slave   capture engine side (consumes the stream, drives the BRAM port)
//     master  environment side (produces the stream, observes the BRAM port)
// -----------------------------------------------------------------------------
interface adc_capture_bram_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 13
);
   logic [DATA_WIDTH-1:0]   s_axis_tdata;
   logic                    s_axis_tvalid;
   logic                    s_axis_tready;
   logic                    bram_en;
   logic [DATA_WIDTH/8-1:0] bram_we;
   logic [ADDR_WIDTH-1:0]   bram_addr;
   logic [DATA_WIDTH-1:0]   bram_din;

   modport slave (
      input  s_axis_tdata,
      input  s_axis_tvalid,
      output s_axis_tready,
      output bram_en,
      output bram_we,
      output bram_addr,
      output bram_din
   );

   modport master (
      output s_axis_tdata,
      output s_axis_tvalid,
      input  s_axis_tready,
      input  bram_en,
      input  bram_we,
      input  bram_addr,
      input  bram_din
   );
endinterface

// File: rtl/adc_capture_bram.sv
// -----------------------------------------------------------------------------
// adc_capture_bram
//   Capture engine: accepts the ADC AXI4-Stream and writes a programmed number
//   of words into the PS-readable BRAM through its native write port.
//
//   Ports:
//     clk      capture clock (stream, BRAM port and control share it)
//     aresetn  asynchronous active-low reset
//     bus      adc_capture_bram_if.slave: ADC stream in, BRAM write port out
//     start    pulse: arm a capture (ignored while busy)
//     abort    pulse: cancel capture, wins over start
//     trig_en  1 = wait for trig after start, 0 = capture immediately
//     trig     external trigger pulse
//     length   words to capture, 0 = full depth (2**ADDR_WIDTH)
//     decim    (only with ADC_CAPTURE_DECIM_EN) write every (decim+1)-th beat
//     busy     high while ARMED or CAPTURING
//     done     sticky completion flag, cleared by the next start
//     wcnt     words written in the current/last capture
//
//   Optional feature macro: ADC_CAPTURE_DECIM_EN adds the decim port and beat
//   decimation. Without it every accepted beat in CAPTURE is written.
// -----------------------------------------------------------------------------
module adc_capture_bram #(
   parameter int DATA_WIDTH  = 64,
   parameter int ADDR_WIDTH  = 13,
   parameter int ADDR_OFFSET = 0
) (
   input  logic                  clk,
   input  logic                  aresetn,
   adc_capture_bram_if.slave     bus,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  trig_en,
   input  logic                  trig,
   input  logic [ADDR_WIDTH-1:0] length,
`ifdef ADC_CAPTURE_DECIM_EN
   input  logic [7:0]            decim,
`endif
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH:0]   wcnt
);

   localparam int BE_W = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] ADDR_BASE = ADDR_WIDTH'(ADDR_OFFSET);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t              state;
   // Capture length with the "0 = full depth" case already expanded, so the
   // terminal compare against wcnt is a plain equality.
   logic [ADDR_WIDTH:0] len_r;
   logic                beat;
   logic                word_sel;
   logic [ADDR_WIDTH:0] wcnt_nxt;

   assign beat     = bus.s_axis_tvalid & bus.s_axis_tready;
   assign wcnt_nxt = wcnt + (ADDR_WIDTH+1)'(1);

`ifdef ADC_CAPTURE_DECIM_EN
   logic [7:0] decim_r;
   // Counts accepted beats modulo (decim_r+1); zero marks the beat to keep,
   // so the first beat after entering CAPTURE is always written.
   logic [7:0] dcnt;
   assign word_sel = (dcnt == 8'd0);
`else
   assign word_sel = 1'b1;
`endif

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state             <= IDLE;
         len_r             <= '0;
         busy              <= 1'b0;
         done              <= 1'b0;
         wcnt              <= '0;
         bus.s_axis_tready <= 1'b0;
         bus.bram_en       <= 1'b0;
         bus.bram_we       <= '0;
         bus.bram_addr     <= '0;
         bus.bram_din      <= '0;
`ifdef ADC_CAPTURE_DECIM_EN
         decim_r           <= '0;
         dcnt              <= '0;
`endif
      end else begin
         // The ADC is never back-pressured; beats outside CAPTURE just fall away.
         bus.s_axis_tready <= 1'b1;
         // Write strobes are single-cycle; address/data hold their last value.
         bus.bram_en       <= 1'b0;
         bus.bram_we       <= '0;

         if (abort) begin
            // done stays as it is and wcnt is held; a write registered on the
            // previous edge is already on the port and completes untouched.
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     len_r <= {(length == '0), length};
                     done  <= 1'b0;
                     wcnt  <= '0;
                     busy  <= 1'b1;
`ifdef ADC_CAPTURE_DECIM_EN
                     decim_r <= decim;
                     dcnt    <= '0;
`endif
                     state <= trig_en ? ARMED : CAPTURE;
                  end
               end

               ARMED: begin
                  // Only reachable one cycle after start, so a trig coincident
                  // with start is never seen here.
                  if (trig) begin
                     state <= CAPTURE;
`ifdef ADC_CAPTURE_DECIM_EN
                     dcnt  <= '0;
`endif
                  end
               end

               CAPTURE: begin
                  if (beat) begin
`ifdef ADC_CAPTURE_DECIM_EN
                     dcnt <= (dcnt == decim_r) ? 8'd0 : dcnt + 8'd1;
`endif
                     if (word_sel) begin
                        bus.bram_en   <= 1'b1;
                        bus.bram_we   <= {BE_W{1'b1}};
                        bus.bram_din  <= bus.s_axis_tdata;
                        // wcnt never exceeds depth-1 here, so the low bits
                        // cover the full 0..depth-1 range without wrapping.
                        bus.bram_addr <= ADDR_BASE + wcnt[ADDR_WIDTH-1:0];
                        wcnt          <= wcnt_nxt;
                        if (wcnt_nxt == len_r) begin
                           state <= DONE;
                           done  <= 1'b1;
                           busy  <= 1'b0;
                        end
                     end
                  end
               end

               DONE: begin
                  state <= IDLE;
               end

               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_adc_capture_bram.sv
// -----------------------------------------------------------------------------
// tb_adc_capture_bram
//   Bench for adc_capture_bram with a 16-word buffer (ADDR_WIDTH = 4).
//   A negedge monitor records every BRAM write; captures are compared against
//   a transaction-level model (first N selected beats after capture start land
//   at addresses 0..N-1), plus cycle-exact hand sequences for latency, trigger,
//   abort and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_adc_capture_bram;

   localparam int DW    = 64;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          aresetn = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          trig_en = 1'b0;
   logic          trig = 1'b0;
   logic [AW-1:0] length = '0;
   logic          busy;
   logic          done;
   logic [AW:0]   wcnt;
`ifdef ADC_CAPTURE_DECIM_EN
   logic [7:0]    decim = 8'd1;
   int            stride = 2;
`else
   int            stride = 1;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;
   wr_t wq[$];

   typedef struct {
      bit            te;
      logic [AW-1:0] len;
      int            pre;
      int            nsel;
      logic [DW-1:0] base;
      int            exp_n;
      int            exp_wcnt;
      bit            exp_done;
   } vec_t;

   always #5 clk = ~clk;

   adc_capture_bram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   adc_capture_bram #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .ADDR_OFFSET(0)
   ) dut (
      .clk     (clk),
      .aresetn (aresetn),
      .bus     (bus),
      .start   (start),
      .abort   (abort),
      .trig_en (trig_en),
      .trig    (trig),
      .length  (length),
`ifdef ADC_CAPTURE_DECIM_EN
      .decim   (decim),
`endif
      .busy    (busy),
      .done    (done),
      .wcnt    (wcnt)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Every issued write is recorded; strobes must be all-or-none.
   always @(negedge clk) begin
      if (aresetn && bus.bram_en === 1'b1) begin
         chk("bram_we_all", 128'(bus.bram_we), 128'({(DW/8){1'b1}}));
         wq.push_back('{addr: bus.bram_addr, data: bus.bram_din});
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Runs one capture and checks it against the transaction model: beats
   // presented after the start cycle (or after the trig cycle when trig_en)
   // are numbered from 0; every stride-th one is kept until len words are
   // kept or the abort point is reached; kept word i lands at address i.
   task automatic run_capture(input bit te, input logic [AW-1:0] len, input int pre,
                              input int nbeats, input bit rnd, input logic [DW-1:0] base,
                              input int abort_after, output int dut_n);
      logic [DW-1:0] exp_q[$];
      logic [DW-1:0] d;
      int  lt;
      int  sent;
      bit  active;
      bit  aborted;
      lt = (len == '0) ? DEPTH : int'(len);
      wq.delete();
      trig_en = te;
      length  = len;
      start   = 1'b1;
      bus.s_axis_tvalid = rnd ? 1'($urandom) : 1'b0;
      bus.s_axis_tdata  = {$urandom, $urandom};
      cyc();
      start  = 1'b0;
      length = AW'($urandom);
      if (te) begin
         for (int i = 0; i < pre; i++) begin
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tdata  = {$urandom, $urandom};
            cyc();
         end
         trig = 1'b1;
         bus.s_axis_tvalid = 1'b0;
         cyc();
         trig = 1'b0;
      end
      active  = 1'b1;
      aborted = 1'b0;
      sent    = 0;
      for (int c = 0; c < 1000 && sent < nbeats; c++) begin
         if (active && abort_after >= 0 && exp_q.size() == abort_after) begin
            abort = 1'b1;
            bus.s_axis_tvalid = 1'b0;
            cyc();
            abort   = 1'b0;
            active  = 1'b0;
            aborted = 1'b1;
            continue;
         end
         if (rnd && ($urandom % 4) == 0) begin
            bus.s_axis_tvalid = 1'b0;
            cyc();
            continue;
         end
         d = rnd ? {$urandom, $urandom} : base + DW'(sent);
         bus.s_axis_tvalid = 1'b1;
         bus.s_axis_tdata  = d;
         if (active) begin
            if (sent % stride == 0) exp_q.push_back(d);
            if (exp_q.size() == lt) active = 1'b0;
         end
         sent++;
         cyc();
      end
      // Trailing beats after completion/abort must be dropped.
      for (int i = 0; i < 3; i++) begin
         bus.s_axis_tvalid = 1'b1;
         bus.s_axis_tdata  = {$urandom, $urandom};
         cyc();
      end
      bus.s_axis_tvalid = 1'b0;
      cyc();
      chk("cap_nwrites", 128'(wq.size()), 128'(exp_q.size()));
      for (int i = 0; i < wq.size() && i < exp_q.size(); i++) begin
         chk("cap_addr", 128'(wq[i].addr), 128'(i));
         chk("cap_data", 128'(wq[i].data), 128'(exp_q[i]));
      end
      chk("cap_wcnt", 128'(wcnt), 128'(exp_q.size()));
      chk("cap_done", 128'(done), 128'(!aborted && exp_q.size() == lt));
      chk("cap_busy", 128'(busy), 128'(0));
      dut_n = wq.size();
   endtask

   initial begin
      vec_t vecs[5];
      int   dn;
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tdata  = '0;

      vecs[0] = '{te: 1'b0, len: 4'd4,  pre: 0, nsel: 6,  base: 64'h10,                  exp_n: 4,  exp_wcnt: 4,  exp_done: 1'b1};
      vecs[1] = '{te: 1'b1, len: 4'd2,  pre: 5, nsel: 3,  base: 64'hA0,                  exp_n: 2,  exp_wcnt: 2,  exp_done: 1'b1};
      vecs[2] = '{te: 1'b0, len: 4'd0,  pre: 0, nsel: 20, base: 64'h100,                 exp_n: 16, exp_wcnt: 16, exp_done: 1'b1};
      vecs[3] = '{te: 1'b0, len: 4'd1,  pre: 0, nsel: 3,  base: 64'hFFFF_FFFF_FFFF_FFF0, exp_n: 1,  exp_wcnt: 1,  exp_done: 1'b1};
      vecs[4] = '{te: 1'b1, len: 4'd15, pre: 1, nsel: 15, base: 64'h5555_0000_0000_0000, exp_n: 15, exp_wcnt: 15, exp_done: 1'b1};

      // Reset state
      cyc();
      cyc();
      chk("rst_tready", 128'(bus.s_axis_tready), 128'(0));
      chk("rst_en",     128'(bus.bram_en), 128'(0));
      chk("rst_we",     128'(bus.bram_we), 128'(0));
      chk("rst_busy",   128'(busy), 128'(0));
      chk("rst_done",   128'(done), 128'(0));
      chk("rst_wcnt",   128'(wcnt), 128'(0));
      aresetn = 1'b1;
      cyc();
      chk("tready_up", 128'(bus.s_axis_tready), 128'(1));

      // Immediate capture, cycle-exact: length 4, six selected beats offered.
      wq.delete();
      trig_en = 1'b0;
      length  = 4'd4;
      start   = 1'b1;
      cyc();
      start  = 1'b0;
      length = 4'd9;
      chk("a_busy", 128'(busy), 128'(1));
      chk("a_wcnt0", 128'(wcnt), 128'(0));
      chk("a_done0", 128'(done), 128'(0));
      for (int j = 0; j < 6 * stride; j++) begin
         bus.s_axis_tvalid = 1'b1;
         bus.s_axis_tdata  = 64'h10 + 64'(j);
         cyc();
         if (j % stride == 0 && j / stride < 4) begin
            chk("a_en",   128'(bus.bram_en), 128'(1));
            chk("a_addr", 128'(bus.bram_addr), 128'(j / stride));
            chk("a_din",  128'(bus.bram_din), 128'(64'h10 + 64'(j)));
            chk("a_wcnt", 128'(wcnt), 128'(j / stride + 1));
         end else begin
            chk("a_noen", 128'(bus.bram_en), 128'(0));
         end
         chk("a_busy_t", 128'(busy), 128'(j < 3 * stride));
         if (j == 3 * stride) chk("a_done", 128'(done), 128'(1));
      end
      bus.s_axis_tvalid = 1'b0;
      cyc();
      chk("a_done_sticky", 128'(done), 128'(1));
      chk("a_wcnt_end", 128'(wcnt), 128'(4));

      // Triggered capture; a trig coincident with start must not count.
      trig_en = 1'b1;
      length  = 4'd2;
      start   = 1'b1;
      trig    = 1'b1;
      cyc();
      start = 1'b0;
      trig  = 1'b0;
      chk("b_busy_armed", 128'(busy), 128'(1));
      chk("b_done_clr", 128'(done), 128'(0));
      for (int j = 0; j < 5; j++) begin
         bus.s_axis_tvalid = 1'b1;
         bus.s_axis_tdata  = 64'h50 + 64'(j);
         cyc();
         chk("b_pretrig_noen", 128'(bus.bram_en), 128'(0));
         chk("b_pretrig_busy", 128'(busy), 128'(1));
      end
      trig = 1'b1;
      bus.s_axis_tvalid = 1'b0;
      cyc();
      trig = 1'b0;
      for (int j = 0; j < 3 * stride; j++) begin
         bus.s_axis_tvalid = 1'b1;
         bus.s_axis_tdata  = 64'hA0 + 64'(j);
         cyc();
         if (j % stride == 0 && j / stride < 2) begin
            chk("b_en",   128'(bus.bram_en), 128'(1));
            chk("b_addr", 128'(bus.bram_addr), 128'(j / stride));
            chk("b_din",  128'(bus.bram_din), 128'(64'hA0 + 64'(j)));
         end else begin
            chk("b_noen", 128'(bus.bram_en), 128'(0));
         end
         chk("b_busy", 128'(busy), 128'(j < stride));
         if (j == stride) chk("b_done", 128'(done), 128'(1));
      end
      bus.s_axis_tvalid = 1'b0;
      cyc();

      // Abort after three words; then start+abort together stays idle.
      trig_en = 1'b0;
      length  = 4'd8;
      start   = 1'b1;
      cyc();
      start = 1'b0;
      for (int j = 0; j < 2 * stride + 1; j++) begin
         bus.s_axis_tvalid = 1'b1;
         bus.s_axis_tdata  = 64'hC0 + 64'(j);
         cyc();
      end
      bus.s_axis_tvalid = 1'b0;
      abort = 1'b1;
      chk("c_pending_en", 128'(bus.bram_en), 128'(1));
      chk("c_pending_addr", 128'(bus.bram_addr), 128'(2));
      cyc();
      abort = 1'b0;
      chk("c_abort_en", 128'(bus.bram_en), 128'(0));
      chk("c_abort_busy", 128'(busy), 128'(0));
      chk("c_abort_done", 128'(done), 128'(0));
      chk("c_abort_wcnt", 128'(wcnt), 128'(3));
      for (int j = 0; j < 4; j++) begin
         bus.s_axis_tvalid = 1'b1;
         bus.s_axis_tdata  = 64'hD0 + 64'(j);
         cyc();
         chk("c_post_noen", 128'(bus.bram_en), 128'(0));
      end
      start = 1'b1;
      abort = 1'b1;
      cyc();
      start = 1'b0;
      abort = 1'b0;
      chk("c_sa_busy", 128'(busy), 128'(0));
      chk("c_sa_wcnt", 128'(wcnt), 128'(3));
      cyc();
      chk("c_sa_noen", 128'(bus.bram_en), 128'(0));
      chk("c_sa_busy2", 128'(busy), 128'(0));
      bus.s_axis_tvalid = 1'b0;
      cyc();

      // Asynchronous reset in the middle of a capture.
      length = 4'd8;
      start  = 1'b1;
      cyc();
      start = 1'b0;
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = 64'hE0;
      cyc();
      bus.s_axis_tdata  = 64'hE1;
      aresetn = 1'b0;
      #1;
      chk("d_rst_en",     128'(bus.bram_en), 128'(0));
      chk("d_rst_we",     128'(bus.bram_we), 128'(0));
      chk("d_rst_busy",   128'(busy), 128'(0));
      chk("d_rst_done",   128'(done), 128'(0));
      chk("d_rst_wcnt",   128'(wcnt), 128'(0));
      chk("d_rst_tready", 128'(bus.s_axis_tready), 128'(0));
      cyc();
      chk("d_rst_hold_en", 128'(bus.bram_en), 128'(0));
      bus.s_axis_tvalid = 1'b0;
      aresetn = 1'b1;
      cyc();

`ifdef ADC_CAPTURE_DECIM_EN
      // Decimation by 3: beats 0..8, length 3 -> words 0, 3, 6.
      decim  = 8'd2;
      stride = 3;
      run_capture(1'b0, 4'd3, 0, 9, 1'b0, 64'h0, -1, dn);
      chk("e_n", 128'(dn), 128'(3));
      for (int i = 0; i < 3 && i < wq.size(); i++) begin
         chk("e_addr", 128'(wq[i].addr), 128'(i));
         chk("e_data", 128'(wq[i].data), 128'(3 * i));
      end
      decim  = 8'd1;
      stride = 2;
`endif

      // Table of directed captures (first one also shows normal capture after reset).
      for (int v = 0; v < 5; v++) begin
         run_capture(vecs[v].te, vecs[v].len, vecs[v].pre, vecs[v].nsel * stride,
                     1'b0, vecs[v].base, -1, dn);
         chk("tbl_n",    128'(dn), 128'(vecs[v].exp_n));
         chk("tbl_wcnt", 128'(wcnt), 128'(vecs[v].exp_wcnt));
         chk("tbl_done", 128'(done), 128'(vecs[v].exp_done));
         for (int i = 0; i < dn && i < wq.size(); i++)
            chk("tbl_data", 128'(wq[i].data), 128'(vecs[v].base + 64'(i * stride)));
      end

      // Randomized captures against the model.
      for (int t = 0; t < 40; t++) begin
         bit            te;
         logic [AW-1:0] len;
         int            lt;
         int            ab;
         te  = 1'($urandom);
         len = AW'($urandom);
         lt  = (len == '0) ? DEPTH : int'(len);
`ifdef ADC_CAPTURE_DECIM_EN
         decim  = 8'($urandom_range(1, 3));
         stride = int'(decim) + 1;
`endif
         ab = (($urandom % 3) == 0) ? int'($urandom % lt) : -1;
         run_capture(te, len, int'($urandom_range(0, 3)), lt * stride + int'($urandom % 3),
                     1'b1, 64'h0, ab, dn);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
